dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/mem_pkg.sv | 25 ++
 rtl/dmem_byte_array.sv | 36 +++
 rtl/dmem_responder.sv | 131 +++++++++++++
 tb/tb_dmem_responder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Store-size and responder-state encodings for the data memory.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2,
        MEM_RSVD = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } rsp_state_e;

    localparam int unsigned CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/dmem_byte_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_byte_array
// Description : Byte-wide backing store, four big-endian lanes at A..A+3.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_byte_array #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        wr_en,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data
);

    logic [7:0]        dmem [0:(2**ADDR_W)-1];
    logic [ADDR_W-1:0] w_lane_addr [4];

    // Lane 0 is the lowest address and sits in the most significant byte;
    // lane addresses wrap naturally at the array size.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign w_lane_addr[g]        = addr + ADDR_W'(g);
        assign rd_data[31-8*g -: 8]  = dmem[w_lane_addr[g]];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en[i]) begin
                dmem[w_lane_addr[i]] <= wr_data[31-8*i -: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Fixed-latency data-memory responder with byte/half/word stores.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_rd_en_i,
    input  logic        dmem_wr_en_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [1:0]  dmem_wr_size_i,
    input  logic [31:0] dmem_wr_data_i,
    output logic        dmem_busy_o,
    output logic        dmem_rdy_o,
    output logic [31:0] dmem_rd_data_o
);

    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(LATENCY - 1);

    rsp_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_busy, r_rdy, r_is_load;
    logic [31:0]      r_rd_hold, r_rd_data;
    logic             w_accept, w_is_store, w_is_load;
    logic [3:0]       w_lane_we;
    logic [31:0]      w_lane_data, w_arr_rdata;
    logic             w_unused_addr;

    assign w_unused_addr = &{1'b0, dmem_addr_i[31:ADDR_W]};

    // A simultaneous read and write request is treated as a store.
    assign w_accept   = (dmem_rd_en_i | dmem_wr_en_i) & ~r_busy;
    assign w_is_store = w_accept & dmem_wr_en_i;
    assign w_is_load  = w_accept & ~dmem_wr_en_i;

    always_comb begin
        w_lane_we   = 4'b0000;
        w_lane_data = 32'h0;
        if (w_is_store) begin
            case (dmem_wr_size_i)
                MEM_BYTE: begin
                    w_lane_we   = 4'b0001;
                    w_lane_data = {dmem_wr_data_i[7:0], 24'h0};
                end
                MEM_HALF: begin
                    w_lane_we   = 4'b0011;
                    w_lane_data = {dmem_wr_data_i[15:0], 16'h0};
                end
                MEM_WORD: begin
                    w_lane_we   = 4'b1111;
                    w_lane_data = dmem_wr_data_i;
                end
                default: ;
            endcase
        end
    end

    dmem_byte_array #(.ADDR_W(ADDR_W)) u_array (
        .clk     (clk),
        .addr    (dmem_addr_i[ADDR_W-1:0]),
        .wr_en   (w_lane_we),
        .wr_data (w_lane_data),
        .rd_data (w_arr_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = c_cnt_load;
                    end
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Load data is sampled from the array on the accepting edge and only
    // presented on the edge that enters RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_rdy     <= 1'b0;
            r_is_load <= 1'b0;
            r_rd_hold <= '0;
            r_rd_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_rdy   <= (w_state_nxt == ST_RESP);
            if (w_accept) begin
                r_is_load <= w_is_load;
                r_rd_hold <= w_arr_rdata;
            end
            if (LATENCY == 1 && w_is_load) begin
                r_rd_data <= w_arr_rdata;
            end else if (r_state == ST_WAIT && w_state_nxt == ST_RESP && r_is_load) begin
                r_rd_data <= r_rd_hold;
            end
        end
    end

    assign dmem_busy_o    = r_busy;
    assign dmem_rdy_o     = r_rdy;
    assign dmem_rd_data_o = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
    import mem_pkg::*;

    localparam int ADDR_W  = 16;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] addr = '0;
    logic [1:0]  size = '0;
    logic [31:0] wdata = '0;
    logic        busy, rdy;
    logic [31:0] rd_data;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q [$];
    logic [31:0] last_load = '0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk            (clk),
        .rst            (rst),
        .dmem_rd_en_i   (rd_en),
        .dmem_wr_en_i   (wr_en),
        .dmem_addr_i    (addr),
        .dmem_wr_size_i (size),
        .dmem_wr_data_i (wdata),
        .dmem_busy_o    (busy),
        .dmem_rdy_o     (rdy),
        .dmem_rd_data_o (rd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [31:0] w);
        logic [15:0] ai;
        for (int i = 0; i < 4; i++) begin
            ai = a + 16'(i);
            dut.u_array.dmem[ai] = w[31-8*i -: 8];
        end
    endtask

    // One request: push the expected rd_data at issue, pop and compare at rdy.
    task automatic txn(input string tag, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] d, input logic [31:0] exp_load);
        int          cyc;
        bit          got;
        logic [31:0] exp;
        @(negedge clk);
        check({tag, ":idle"}, {31'b0, busy}, 32'd0);
        rd_en = rd; wr_en = wr; addr = a; size = sz; wdata = d;
        exp_q.push_back(wr ? last_load : exp_load);
        @(posedge clk);
        #1;
        rd_en = 1'b0; wr_en = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (rdy) got = 1'b1;
            else check({tag, ":busy"}, {31'b0, busy}, 32'd1);
        end
        check({tag, ":lat"}, 32'(cyc), 32'(LATENCY));
        exp = exp_q.pop_front();
        if (got) begin
            check({tag, ":data"}, rd_data, exp);
            check({tag, ":busy_rdy"}, {31'b0, busy}, 32'd1);
            if (!wr) last_load = exp;
        end
    endtask

    initial begin
        preload(16'h0100, 32'h11223344);
        preload(16'h0104, 32'h55667788);
        preload(16'h0200, 32'h00000000);
        preload(16'h0300, 32'h9ABCDEF0);
        preload(16'h0400, 32'h00000000);
        preload(16'h0500, 32'h00000000);
        preload(16'hFFFC, 32'h00000000);
        preload(16'h0000, 32'h00000000);

        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_rdy", {31'b0, rdy}, 32'd0);
        check("rst_data", rd_data, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        txn("ld100", 1'b1, 1'b0, 32'h0100, MEM_WORD, 32'h0, 32'h11223344);
        txn("stw102", 1'b0, 1'b1, 32'h0102, MEM_WORD, 32'hDEADBEEF, 32'h0);
        txn("ld100b", 1'b1, 1'b0, 32'h0100, MEM_WORD, 32'h0, 32'h1122DEAD);
        txn("ld104", 1'b1, 1'b0, 32'h0104, MEM_WORD, 32'h0, 32'hBEEF7788);
        txn("ldhi", 1'b1, 1'b0, 32'h0001_0100, MEM_WORD, 32'h0, 32'h1122DEAD);
        txn("stb200", 1'b0, 1'b1, 32'h0200, MEM_BYTE, 32'hFFFFFFA5, 32'h0);
        txn("ld200a", 1'b1, 1'b0, 32'h0200, MEM_WORD, 32'h0, 32'hA5000000);
        txn("sth200", 1'b0, 1'b1, 32'h0200, MEM_HALF, 32'hFFFF1234, 32'h0);
        txn("ld200b", 1'b1, 1'b0, 32'h0200, MEM_WORD, 32'h0, 32'h12340000);
        txn("strsvd", 1'b0, 1'b1, 32'h0300, MEM_RSVD, 32'hFFFFFFFF, 32'h0);
        txn("ld300", 1'b1, 1'b0, 32'h0300, MEM_WORD, 32'h0, 32'h9ABCDEF0);
        txn("stwrap", 1'b0, 1'b1, 32'hFFFE, MEM_WORD, 32'hCAFEF00D, 32'h0);
        txn("ldfffe", 1'b1, 1'b0, 32'hFFFE, MEM_WORD, 32'h0, 32'hCAFEF00D);
        txn("ld0000", 1'b1, 1'b0, 32'h0000, MEM_WORD, 32'h0, 32'hF00D0000);

        // Both enables held for 10 edges: accepts at edges 1,4,7,10.
        @(negedge clk);
        rd_en = 1'b1; wr_en = 1'b1; addr = 32'h0400; size = MEM_WORD; wdata = 32'h01020304;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check($sformatf("hold_busy%0d", k), {31'b0, busy}, {31'b0, (k % 3) != 0});
            check($sformatf("hold_rdy%0d", k), {31'b0, rdy}, {31'b0, (k % 3) == 2});
            if (rdy) check($sformatf("hold_data%0d", k), rd_data, last_load);
        end
        rd_en = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        check("hold_last_rdy", {31'b0, rdy}, 32'd1);
        txn("ld400", 1'b1, 1'b0, 32'h0400, MEM_WORD, 32'h0, 32'h01020304);

        // Reset during WAIT after a committed byte store.
        @(negedge clk);
        wr_en = 1'b1; addr = 32'h0500; size = MEM_BYTE; wdata = 32'h00000077;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        check("mid_busy", {31'b0, busy}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_rdy", {31'b0, rdy}, 32'd0);
        check("arst_data", rd_data, 32'h0);
        last_load = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("post_rst_rdy%0d", k), {31'b0, rdy}, 32'd0);
        end
        txn("ld500", 1'b1, 1'b0, 32'h0500, MEM_WORD, 32'h0, 32'h77000000);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
